// File: rtl/dot_stream_mac.sv
// Streaming signed dot-product MAC.
// Accepts one (a, b) pair per accept and sums N products using one multiplier.
// Each result is presented over a valid/ready output handshake.
// The result is the low WIDTH bits of the exact sum; out_ovf flags when the
// exact sum does not fit in signed WIDTH.
//
// state  | meaning
// -------+----------------------------------------------------------
// ACCUM  | accepting element pairs, building the partial sum
// RESULT | holding a finished result until downstream takes it
module dot_stream_mac #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  // Wide enough that N full products can never overflow the partial sum.
  localparam int AW = 2*WIDTH + $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    ACCUM  = 1'b0,
    RESULT = 1'b1
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]           count;
  logic signed [AW-1:0]    acc;
  logic signed [AW-1:0]    sum;
  logic signed [2*WIDTH-1:0] a_ext;
  logic signed [2*WIDTH-1:0] b_ext;
  logic signed [2*WIDTH-1:0] prod;
  logic                    accept;
  logic                    sum_ovf;

  // Flush wins over a same-cycle accept, so the pair it coincides with is dropped.
  assign accept = in_valid && (state == ACCUM) && !flush;

  assign a_ext = {{WIDTH{in_a[WIDTH-1]}}, in_a};
  assign b_ext = {{WIDTH{in_b[WIDTH-1]}}, in_b};
  assign prod  = a_ext * b_ext;
  assign sum   = acc + {{(AW-2*WIDTH){prod[2*WIDTH-1]}}, prod};

  // The sum fits in signed WIDTH only when every bit from WIDTH-1 upward matches the sign.
  assign sum_ovf = !((&sum[AW-1:WIDTH-1]) || !(|sum[AW-1:WIDTH-1]));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (accept && (count == LAST)) state_next = RESULT;
      end
      RESULT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
    if (flush) state_next = ACCUM;
  end

  // Partial sum, element count, and the held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      acc      <= '0;
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else if (flush) begin
      count <= '0;
      acc   <= '0;
    end else if (accept) begin
      if (count == LAST) begin
        out_data <= sum[WIDTH-1:0];
        out_ovf  <= sum_ovf;
        count    <= '0;
        acc      <= '0;
      end else begin
        count <= count + 1'b1;
        acc   <= sum;
      end
    end
  end

endmodule

// File: tb/tb_dot_stream_mac.sv
// Bench for dot_stream_mac.
// A queue-based model collects signed products and sums them once N products
// are present. Outputs are compared every cycle on the falling edge.
module tb_dot_stream_mac;
  localparam int WIDTH = 8;
  localparam int N     = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_ovf;

  always #5 clk = ~clk;

  dot_stream_mac #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  int nchk = 0;
  int nerr = 0;

  // Model state: products of the vector in progress, and the pending result.
  int         prods[$];
  bit         pend;
  logic [7:0] exp_d;
  bit         exp_o;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    nchk++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic compare();
    chk("out_valid", {31'd0, out_valid}, {31'd0, pend});
    chk("in_ready", {31'd0, in_ready}, {31'd0, !pend});
    if (pend) begin
      chk("out_data", {24'd0, out_data}, {24'd0, exp_d});
      chk("out_ovf", {31'd0, out_ovf}, {31'd0, exp_o});
    end
  endtask

  task automatic model_step(input bit v, input logic [7:0] a, input logic [7:0] b,
                            input bit ordy, input bit fl);
    int sa;
    int sb;
    int s;
    if (fl) begin
      prods.delete();
      pend = 1'b0;
    end else if (pend) begin
      if (ordy) pend = 1'b0;
    end else if (v) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      prods.push_back(sa * sb);
      if (prods.size() == N) begin
        s = 0;
        foreach (prods[i]) s += prods[i];
        exp_d = s[7:0];
        exp_o = (s > 127) || (s < -128);
        pend  = 1'b1;
        prods.delete();
      end
    end
  endtask

  // Entered and left on a falling edge.
  task automatic cycle(input bit v, input logic [7:0] a, input logic [7:0] b,
                       input bit ordy, input bit fl);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    model_step(v, a, b, ordy, fl);
    @(negedge clk);
    compare();
  endtask

  task automatic feed(input logic [7:0] a[4], input logic [7:0] b[4]);
    for (int i = 0; i < 4; i++) cycle(1'b1, a[i], b[i], 1'b0, 1'b0);
  endtask

  // Streams a vector back to back, then checks a hand-computed result and takes it.
  task automatic run_vec(input string nm, input logic [7:0] a[4], input logic [7:0] b[4],
                         input logic [7:0] ed, input bit eo);
    feed(a, b);
    chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({nm, "_data"}, {24'd0, out_data}, {24'd0, ed});
    chk({nm, "_ovf"}, {31'd0, out_ovf}, {31'd0, eo});
    cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
  endtask

  logic [7:0] va2[4];
  logic [7:0] vb2[4];
  logic [7:0] vz[4];
  logic [7:0] vff[4];
  logic [7:0] v7f[4];

  initial begin
    va2 = '{8'h03, 8'h01, 8'h01, 8'h02};
    vb2 = '{8'h03, 8'h01, 8'h02, 8'h01};
    vz  = '{8'h00, 8'h00, 8'h00, 8'h00};
    vff = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    v7f = '{8'h7F, 8'h7F, 8'h7F, 8'h7F};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    pend = 1'b0; exp_d = '0; exp_o = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

    run_vec("zeros", vz, vz, 8'h00, 1'b0);
    run_vec("small", va2, vb2, 8'h0E, 1'b0);
    run_vec("neg1", vff, vff, 8'h04, 1'b0);
    run_vec("max", v7f, v7f, 8'h04, 1'b1);

    // Backpressure: the result must hold while inputs are refused.
    feed(va2, vb2);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b0);
      chk("hold_data", {24'd0, out_data}, 32'h0E);
    end
    cycle(1'b1, 8'h55, 8'h55, 1'b1, 1'b0);
    chk("after_hs_ready", {31'd0, in_ready}, 32'd1);
    run_vec("no_carry", v7f, v7f, 8'h04, 1'b1);

    // Bubbles between elements 2 and 3.
    cycle(1'b1, va2[0], vb2[0], 1'b0, 1'b0);
    cycle(1'b1, va2[1], vb2[1], 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'hAA, 8'h77, 1'b0, 1'b0);
    cycle(1'b1, va2[2], vb2[2], 1'b0, 1'b0);
    cycle(1'b1, va2[3], vb2[3], 1'b0, 1'b0);
    chk("bubble_data", {24'd0, out_data}, 32'h0E);
    cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

    // Flush after two pairs; the pair presented with flush is dropped.
    cycle(1'b1, 8'h7F, 8'h7F, 1'b0, 1'b0);
    cycle(1'b1, 8'h7F, 8'h7F, 1'b0, 1'b0);
    cycle(1'b1, 8'h7F, 8'h7F, 1'b0, 1'b1);
    run_vec("post_flush", va2, vb2, 8'h0E, 1'b0);

    // Flush beats a same-cycle output handshake and clears the pending result.
    feed(vff, vff);
    cycle(1'b1, 8'h01, 8'h01, 1'b1, 1'b1);
    run_vec("flush_result", va2, vb2, 8'h0E, 1'b0);

    // Asynchronous reset while a result is pending.
    feed(va2, vb2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_data", {24'd0, out_data}, 32'd0);
    pend = 1'b0;
    prods.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    run_vec("post_rst", vff, vff, 8'h04, 1'b0);

    // Randomized traffic with bubbles, backpressure and occasional flush.
    for (int i = 0; i < 600; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 8'h80 : 8'h7F) : 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 8'h80 : 8'h7F) : 8'($urandom);
      cycle($urandom_range(0, 3) != 0, ra, rb, $urandom_range(0, 2) != 0,
            $urandom_range(0, 40) == 0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
